id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32 core.
- Captures decoded operands, register addresses and control bits from ID. Presents them to EX, where the forwarding unit compares the captured rs1/rs2 addresses against the EX/MEM and MEM/WB destinations.
- Supports stall (hold), flush (bubble insertion) and write-back capture, so operands held during a stall do not go stale.

---
 rtl/core_pkg.sv | 30 +++
 rtl/wb_capture_mux.sv | 23 ++
 rtl/id_ex_pipe_reg.sv | 118 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, ALU op encodings and control bundle for the RV32 pipeline
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_BRSUB = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ITYPE = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic [1:0] aluOp;
    } ctrl_t;

    // x0 is hardwired to zero, so a write to it can never be a forwarding source.
    function automatic logic wbHits(input logic wbWe,
                                    input logic [REG_AW-1:0] wbRd,
                                    input logic [REG_AW-1:0] srcAddr);
        return wbWe && (wbRd != '0) && (wbRd == srcAddr);
    endfunction

endpackage

// File: rtl/wb_capture_mux.sv
// rtl/wb_capture_mux.sv - selects write-back data over base operand when MEM/WB targets the source
module wb_capture_mux
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] srcAddr,
    input  logic [XLEN-1:0]   baseData,
    input  logic              wbRegWrite,
    input  logic [REG_AW-1:0] wbRd,
    input  logic [XLEN-1:0]   wbData,
    output logic [XLEN-1:0]   selData
);

    always_comb begin
        selData = baseData;
        if (wbHits(wbRegWrite, wbRd, srcAddr)) begin
            selData = wbData;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush and write-back capture
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [9:0]        funct_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              alu_src_i,
    input  logic [1:0]        alu_op_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [9:0]        funct_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              alu_src_o,
    output logic [1:0]        alu_op_o,
    output logic              valid_o
);

    ctrl_t             ctrlQ;
    logic [XLEN-1:0]   rs1Next;
    logic [XLEN-1:0]   rs2Next;
    logic [REG_AW-1:0] rs1Src;
    logic [REG_AW-1:0] rs2Src;
    logic [XLEN-1:0]   rs1Base;
    logic [XLEN-1:0]   rs2Base;

    // While stalled the held instruction's sources are matched, so a retiring producer refreshes them.
    assign rs1Src  = stall_i ? rs1_addr_o : rs1_addr_i;
    assign rs2Src  = stall_i ? rs2_addr_o : rs2_addr_i;
    assign rs1Base = stall_i ? rs1_data_o : rs1_data_i;
    assign rs2Base = stall_i ? rs2_data_o : rs2_data_i;

    wb_capture_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs1Capture (
        .srcAddr    (rs1Src),
        .baseData   (rs1Base),
        .wbRegWrite (wb_reg_write_i),
        .wbRd       (wb_rd_i),
        .wbData     (wb_data_i),
        .selData    (rs1Next)
    );

    wb_capture_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs2Capture (
        .srcAddr    (rs2Src),
        .baseData   (rs2Base),
        .wbRegWrite (wb_reg_write_i),
        .wbRd       (wb_rd_i),
        .wbData     (wb_data_i),
        .selData    (rs2Next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            pc_o       <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            funct_o    <= '0;
            ctrlQ      <= '0;
            valid_o    <= 1'b0;
        end else begin
            rs1_data_o <= rs1Next;
            rs2_data_o <= rs2Next;
            if (!stall_i) begin
                pc_o       <= pc_i;
                imm_o      <= imm_i;
                rs1_addr_o <= rs1_addr_i;
                rs2_addr_o <= rs2_addr_i;
                rd_addr_o  <= rd_addr_i;
                funct_o    <= funct_i;
                ctrlQ      <= '{regWrite: reg_write_i && (rd_addr_i != '0),
                                memToReg: mem_to_reg_i,
                                memRead:  mem_read_i,
                                memWrite: mem_write_i,
                                aluSrc:   alu_src_i,
                                aluOp:    alu_op_i};
                valid_o    <= 1'b1;
            end
        end
    end

    assign reg_write_o  = ctrlQ.regWrite;
    assign mem_to_reg_o = ctrlQ.memToReg;
    assign mem_read_o   = ctrlQ.memRead;
    assign mem_write_o  = ctrlQ.memWrite;
    assign alu_src_o    = ctrlQ.aluSrc;
    assign alu_op_o     = ctrlQ.aluOp;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_i, stall_i, flush_i;
    logic [XLEN-1:0]   pc_i, rs1_data_i, rs2_data_i, imm_i, wb_data_i;
    logic [REG_AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i, wb_rd_i;
    logic [9:0]        funct_i;
    logic              reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, wb_reg_write_i;
    logic [1:0]        alu_op_i;
    logic [XLEN-1:0]   pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [REG_AW-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [9:0]        funct_o;
    logic              reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, valid_o;
    logic [1:0]        alu_op_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .funct_i(funct_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .alu_src_i(alu_src_i),
        .alu_op_i(alu_op_i), .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i),
        .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .funct_o(funct_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .alu_src_o(alu_src_o),
        .alu_op_o(alu_op_o), .valid_o(valid_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rst_i = 0; stall_i = 0; flush_i = 0;
        pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; wb_data_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; wb_rd_i = '0;
        funct_i = '0; reg_write_i = 0; mem_to_reg_i = 0; mem_read_i = 0;
        mem_write_i = 0; alu_src_i = 0; alu_op_i = '0; wb_reg_write_i = 0;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] ones = '1;
        pc_i = ones; rs1_data_i = ones; rs2_data_i = ones; imm_i = ones; wb_data_i = ones;
        rs1_addr_i = '1; rs2_addr_i = '1; rd_addr_i = '1; wb_rd_i = '1; funct_i = '1;
        reg_write_i = 1; mem_to_reg_i = 1; mem_read_i = 1; mem_write_i = 1; alu_src_i = 1;
        alu_op_i = '1; wb_reg_write_i = 1; stall_i = 1; flush_i = 1; rst_i = 1;
        tick();
        tick();
        checks++;
        if ({pc_o, rs1_data_o, rs2_data_o, imm_o} !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0", pc_o, rs1_data_o, rs2_data_o, imm_o);
        end
        checks++;
        if ({rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o} !== '0) begin
            errors++; $display("FAIL reset_addr: got %h %h %h %h expected all 0", rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o);
        end
        checks++;
        if ({reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o, valid_o} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
                {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o, valid_o});
        end
        rst_i = 0; stall_i = 0; flush_i = 0;
        tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFF || rd_addr_o !== 5'h1F) begin
            errors++; $display("FAIL reset_release_load: got valid=%b pc=%h rd=%h expected 1 ffffffff 1f", valid_o, pc_o, rd_addr_o);
        end
        checks++;
        if ({reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o} !== 7'h7F || funct_o !== 10'h3FF) begin
            errors++; $display("FAIL reset_release_ctrl: got %b funct=%h expected 1111111 3ff",
                {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o}, funct_o);
        end
    endtask

    task automatic test_load();
        clearInputs();
        rd_addr_i = 5; reg_write_i = 1; rs1_data_i = 32'h11; rs1_addr_i = 2; alu_op_i = 2'b10;
        imm_i = 32'hFFFF_FFF0; funct_i = 10'h205;
        tick();
        checks++;
        if (rd_addr_o !== 5'd5 || reg_write_o !== 1'b1 || rs1_data_o !== 32'h11 || valid_o !== 1'b1) begin
            errors++; $display("FAIL load_basic: got rd=%0d rw=%b rs1=%h v=%b expected 5 1 11 1", rd_addr_o, reg_write_o, rs1_data_o, valid_o);
        end
        checks++;
        if (alu_op_o !== 2'b10 || imm_o !== 32'hFFFF_FFF0 || funct_o !== 10'h205 || rs1_addr_o !== 5'd2) begin
            errors++; $display("FAIL load_fields: got op=%b imm=%h funct=%h rs1a=%0d expected 10 fffffff0 205 2", alu_op_o, imm_o, funct_o, rs1_addr_o);
        end
        rd_addr_i = 0;
        tick();
        checks++;
        if (reg_write_o !== 1'b0 || valid_o !== 1'b1) begin
            errors++; $display("FAIL load_x0_rw: got rw=%b v=%b expected 0 1", reg_write_o, valid_o);
        end
    endtask

    task automatic test_stall_capture();
        clearInputs();
        rs1_addr_i = 3; rs1_data_i = 32'hAA; rd_addr_i = 4; reg_write_i = 1; pc_i = 32'h100;
        tick();
        stall_i = 1; wb_reg_write_i = 1; wb_rd_i = 3; wb_data_i = 32'hBB;
        pc_i = 32'h200; rs1_data_i = 32'hCC; rd_addr_i = 9;
        tick();
        checks++;
        if (rs1_data_o !== 32'hBB) begin
            errors++; $display("FAIL stall_capture_rs1: got %h expected bb", rs1_data_o);
        end
        checks++;
        if (pc_o !== 32'h100 || rd_addr_o !== 5'd4 || rs1_addr_o !== 5'd3 || reg_write_o !== 1'b1 || valid_o !== 1'b1) begin
            errors++; $display("FAIL stall_capture_hold: got pc=%h rd=%0d rs1a=%0d rw=%b v=%b expected 100 4 3 1 1",
                pc_o, rd_addr_o, rs1_addr_o, reg_write_o, valid_o);
        end
        clearInputs();
        rs1_addr_i = 3; rs1_data_i = 32'hAA; rd_addr_i = 4; reg_write_i = 1;
        tick();
        stall_i = 1; wb_reg_write_i = 1; wb_rd_i = 0; wb_data_i = 32'hBB;
        tick();
        checks++;
        if (rs1_data_o !== 32'hAA) begin
            errors++; $display("FAIL stall_capture_x0: got %h expected aa", rs1_data_o);
        end
        wb_rd_i = 3; wb_reg_write_i = 0;
        tick();
        checks++;
        if (rs1_data_o !== 32'hAA) begin
            errors++; $display("FAIL stall_capture_nowe: got %h expected aa", rs1_data_o);
        end
    endtask

    task automatic test_load_bypass();
        clearInputs();
        rs2_addr_i = 7; rs2_data_i = 32'h1; rs1_addr_i = 7; rs1_data_i = 32'h5;
        wb_reg_write_i = 1; wb_rd_i = 7; wb_data_i = 32'h2;
        tick();
        checks++;
        if (rs2_data_o !== 32'h2 || rs1_data_o !== 32'h2) begin
            errors++; $display("FAIL load_bypass: got rs1=%h rs2=%h expected 2 2", rs1_data_o, rs2_data_o);
        end
        rs1_addr_i = 6; rs1_data_i = 32'h5;
        tick();
        checks++;
        if (rs2_data_o !== 32'h2 || rs1_data_o !== 32'h5) begin
            errors++; $display("FAIL load_bypass_one: got rs1=%h rs2=%h expected 5 2", rs1_data_o, rs2_data_o);
        end
    endtask

    task automatic test_flush_vs_stall();
        clearInputs();
        rd_addr_i = 9; reg_write_i = 1; mem_write_i = 1; alu_op_i = 2'b11; rs1_addr_i = 4; pc_i = 32'h80;
        tick();
        stall_i = 1; flush_i = 1;
        tick();
        checks++;
        if (valid_o !== 1'b0 || reg_write_o !== 1'b0 || mem_write_o !== 1'b0 || rd_addr_o !== 5'd0) begin
            errors++; $display("FAIL flush_vs_stall: got v=%b rw=%b mw=%b rd=%0d expected 0 0 0 0", valid_o, reg_write_o, mem_write_o, rd_addr_o);
        end
        checks++;
        if (alu_op_o !== 2'b00 || rs1_addr_o !== 5'd0 || pc_o !== 32'h0) begin
            errors++; $display("FAIL flush_bubble: got op=%b rs1a=%0d pc=%h expected 00 0 0", alu_op_o, rs1_addr_o, pc_o);
        end
    endtask

    task automatic test_stall_hold();
        clearInputs();
        pc_i = 32'h40; rd_addr_i = 6; imm_i = 32'h123; reg_write_i = 1; rs2_data_i = 32'h77; rs2_addr_i = 1;
        tick();
        stall_i = 1;
        for (int i = 1; i <= 3; i++) begin
            pc_i = 32'h40 + 32'(4 * i); rd_addr_i = 5'(10 + i); imm_i = 32'(i); rs2_data_i = 32'(i);
            tick();
            checks++;
            if (pc_o !== 32'h40 || rd_addr_o !== 5'd6 || imm_o !== 32'h123 || rs2_data_o !== 32'h77 || valid_o !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d: got pc=%h rd=%0d imm=%h rs2=%h v=%b expected 40 6 123 77 1",
                    i, pc_o, rd_addr_o, imm_o, rs2_data_o, valid_o);
            end
        end
        stall_i = 0; pc_i = 32'h50; rd_addr_i = 8;
        tick();
        checks++;
        if (pc_o !== 32'h50 || rd_addr_o !== 5'd8) begin
            errors++; $display("FAIL stall_release: got pc=%h rd=%0d expected 50 8", pc_o, rd_addr_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        clearInputs();
        pc_i = 32'h60; rd_addr_i = 3; reg_write_i = 1;
        tick();
        stall_i = 1; rst_i = 1;
        tick();
        checks++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0 || reg_write_o !== 1'b0 || rd_addr_o !== 5'd0) begin
            errors++; $display("FAIL reset_mid_stall: got v=%b pc=%h rw=%b rd=%0d expected 0 0 0 0", valid_o, pc_o, reg_write_o, rd_addr_o);
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_load();
        test_stall_capture();
        test_load_bypass();
        test_flush_vs_stall();
        test_stall_hold();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
